// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b pipeline types, hazard FSM states and bypass select codes
package lc3b_types;
  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} lc3b_hazard_state;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
endpackage

// File: rtl/hazard_forward_unit_forward_match.sv
// forward_match: per-source bypass select and load-use term
module forward_match
  import lc3b_types::*;
#(
  parameter int REG_W = 3
) (
  input  logic [REG_W-1:0] src,
  input  logic             src_valid,
  input  logic             mem_valid,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_load_regfile,
  input  logic             mem_mem_read,
  input  logic             wb_valid,
  input  logic             wb_load_regfile,
  input  logic [REG_W-1:0] wb_dest,
  output logic [1:0]       sel,
  output logic             lu
);
  logic mem_hit, wb_hit;
  always_comb begin
    mem_hit = src_valid && mem_valid && mem_load_regfile && src == mem_dest;
    wb_hit  = src_valid && wb_valid && wb_load_regfile && src == wb_dest;
    sel     = mem_hit && !mem_mem_read ? FWD_MEM : wb_hit ? FWD_WB : FWD_RF;
    lu      = mem_hit && mem_mem_read;
  end
endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: operand bypass selects, load-use bubbles, MEM wait stalls with watchdog and stall counter
module hazard_forward_unit
  import lc3b_types::*;
#(
  parameter int NUM_SRC = 3,
  parameter int REG_W   = 3,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_SRC-1:0][REG_W-1:0] ex_src,
  input  logic [NUM_SRC-1:0]            ex_src_valid,
  input  logic                          ex_flush,
  input  logic                          mem_valid,
  input  logic [REG_W-1:0]              mem_dest,
  input  logic                          mem_load_regfile,
  input  logic                          mem_mem_read,
  input  logic                          mem_req,
  input  logic                          mem_resp,
  input  logic                          wb_valid,
  input  logic                          wb_load_regfile,
  input  logic [REG_W-1:0]              wb_dest,
  output logic [NUM_SRC-1:0][1:0]       fwd_sel,
  output logic                          stall_front,
  output logic                          stall_mem,
  output logic                          bubble_mem,
  output logic                          bubble_wb,
  output logic                          fault,
  output logic [CNT_W-1:0]              stall_cycles
);
  localparam int WD_W = $clog2(TIMEOUT + 1) + 1;
  lc3b_hazard_state state_q, state_d;
  logic [WD_W-1:0] wdog_q, wdog_d, wdog_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_SRC-1:0][1:0] sel;
  logic [NUM_SRC-1:0] lu_src;
  logic lu, mem_busy, hold, wd_hit;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    forward_match #(.REG_W(REG_W)) u_match (
      .src              (ex_src[i]),
      .src_valid        (ex_src_valid[i]),
      .mem_valid        (mem_valid),
      .mem_dest         (mem_dest),
      .mem_load_regfile (mem_load_regfile),
      .mem_mem_read     (mem_mem_read),
      .wb_valid         (wb_valid),
      .wb_load_regfile  (wb_load_regfile),
      .wb_dest          (wb_dest),
      .sel              (sel[i]),
      .lu               (lu_src[i])
    );
  end
  always_comb begin
    lu          = |lu_src && !ex_flush;
    mem_busy    = mem_valid && mem_req && !mem_resp;
    hold        = state_q == FAULT || (state_q == MEM_WAIT ? !mem_resp : mem_busy);
    wdog_inc    = wdog_q + 1'b1;
    wd_hit      = TIMEOUT != 0 && wdog_inc == WD_W'(TIMEOUT);
    state_d     = state_q == FAULT ? FAULT :
                  state_q == MEM_WAIT ? (mem_resp ? RUN : wd_hit ? FAULT : MEM_WAIT) :
                  mem_busy ? MEM_WAIT : RUN;
    wdog_d      = state_q == MEM_WAIT ? wdog_inc : '0;
    stall_front = reset_n && (hold || lu);
    stall_mem   = reset_n && hold;
    bubble_wb   = reset_n && hold;
    bubble_mem  = reset_n && lu && !hold;
    fwd_sel     = reset_n ? sel : '0;
    cnt_d       = stall_front && cnt_q != '1 ? cnt_q + 1'b1 : cnt_q;
    fault       = state_q == FAULT;
  end
  always_ff @(posedge clk) begin
    state_q <= !reset_n ? RUN : state_d;
    wdog_q  <= !reset_n ? '0 : wdog_d;
    cnt_q   <= !reset_n ? '0 : cnt_d;
  end
  assign stall_cycles = cnt_q;
endmodule
